// File: rtl/riscv_idex_stage_pkg.sv
// Shared types and constants for the ID/EX stage: ALU control codes, operand selects, control payload.
// The optional forwarding path is enabled by the RISCV_FWD_EN macro.
package riscv_idex_stage_pkg;

    localparam int unsigned DEF_XLEN   = 32;
    localparam int unsigned REG_AW     = 5;
    localparam int unsigned ALU_CTRL_W = 4;

    typedef enum logic [ALU_CTRL_W-1:0] {
        ALU_CTRL_ADD  = 4'h0,
        ALU_CTRL_SUB  = 4'h1,
        ALU_CTRL_SLL  = 4'h2,
        ALU_CTRL_SLT  = 4'h3,
        ALU_CTRL_SLTU = 4'h4,
        ALU_CTRL_XOR  = 4'h5,
        ALU_CTRL_SRL  = 4'h6,
        ALU_CTRL_SRA  = 4'h7,
        ALU_CTRL_OR   = 4'h8,
        ALU_CTRL_AND  = 4'h9
    } alu_ctrl_e;

    typedef enum logic {
        SRC_A_RS1 = 1'b0,
        SRC_A_PC  = 1'b1
    } src_a_e;

    typedef enum logic {
        SRC_B_RS2 = 1'b0,
        SRC_B_IMM = 1'b1
    } src_b_e;

    // Control fields carried alongside the operands into execute.
    typedef struct packed {
        alu_ctrl_e           alu_ctrl;
        src_a_e              src_a_sel;
        src_b_e              src_b_sel;
        logic [REG_AW-1:0]   rd_addr;
    } idex_ctrl_t;

    // A producer matches an operand when it writes that register and the register is not x0.
    function automatic logic fwd_hit(
        input logic [REG_AW-1:0] rs_addr,
        input logic [REG_AW-1:0] rd_addr,
        input logic              rd_we
    );
        return rd_we && (rd_addr == rs_addr) && (rs_addr != REG_AW'(0));
    endfunction

endpackage

// File: rtl/riscv_fwd_mux.sv
// Per-operand forwarding select: EX/MEM beats MEM/WB beats the base value.
// Instantiated only when RISCV_FWD_EN is defined.
module riscv_fwd_mux
    import riscv_idex_stage_pkg::*;
#(
    parameter int unsigned XLEN = DEF_XLEN
) (
    input  logic [REG_AW-1:0] i_rs_addr,
    input  logic [XLEN-1:0]   i_base,
    input  logic [REG_AW-1:0] i_exmem_rd_addr,
    input  logic              i_exmem_rd_we,
    input  logic [XLEN-1:0]   i_exmem_result,
    input  logic [REG_AW-1:0] i_memwb_rd_addr,
    input  logic              i_memwb_rd_we,
    input  logic [XLEN-1:0]   i_memwb_result,
    output logic [XLEN-1:0]   o_value
);

    always_comb begin
        o_value = i_base;
        if (fwd_hit(i_rs_addr, i_memwb_rd_addr, i_memwb_rd_we)) begin
            o_value = i_memwb_result;
        end
        if (fwd_hit(i_rs_addr, i_exmem_rd_addr, i_exmem_rd_we)) begin
            o_value = i_exmem_result;
        end
    end

endmodule

// File: rtl/riscv_idex_stage.sv
// ID/EX pipeline register feeding the ALU, with valid/ready handshake, stall and flush.
// Define RISCV_FWD_EN to resolve RAW hazards by forwarding from EX/MEM and MEM/WB.
module riscv_idex_stage
    import riscv_idex_stage_pkg::*;
#(
    parameter int unsigned XLEN = DEF_XLEN
) (
    input  logic                  i_clk,
    input  logic                  i_rstn,
    input  logic                  i_id_valid,
    output logic                  o_id_ready,
    input  logic [XLEN-1:0]       i_id_pc,
    input  logic [XLEN-1:0]       i_id_rs1_data,
    input  logic [XLEN-1:0]       i_id_rs2_data,
    input  logic [REG_AW-1:0]     i_id_rs1_addr,
    input  logic [REG_AW-1:0]     i_id_rs2_addr,
    input  logic [XLEN-1:0]       i_id_imm,
    input  logic [ALU_CTRL_W-1:0] i_id_alu_ctrl,
    input  logic                  i_id_src_a_sel,
    input  logic                  i_id_src_b_sel,
    input  logic [REG_AW-1:0]     i_id_rd_addr,
    input  logic                  i_id_rd_we,
    input  logic                  i_flush,
    input  logic                  i_ex_ready,
    input  logic [REG_AW-1:0]     i_exmem_rd_addr,
    input  logic                  i_exmem_rd_we,
    input  logic [XLEN-1:0]       i_exmem_result,
    input  logic [REG_AW-1:0]     i_memwb_rd_addr,
    input  logic                  i_memwb_rd_we,
    input  logic [XLEN-1:0]       i_memwb_result,
    output logic                  o_ex_valid,
    output logic [XLEN-1:0]       o_alu_a,
    output logic [XLEN-1:0]       o_alu_b,
    output logic [ALU_CTRL_W-1:0] o_alu_ctrl,
    output logic [XLEN-1:0]       o_ex_rs2_data,
    output logic [REG_AW-1:0]     o_ex_rd_addr,
    output logic                  o_ex_rd_we,
    output logic [XLEN-1:0]       o_ex_pc
);

    logic            r_valid;
    logic            r_rd_we;
    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] r_rs1;
    logic [XLEN-1:0] r_rs2;
    logic [XLEN-1:0] r_imm;
    idex_ctrl_t      r_ctrl;

    logic            w_load;
    logic            w_stall;
    logic [XLEN-1:0] w_rs1_next;
    logic [XLEN-1:0] w_rs2_next;

    assign o_id_ready = !r_valid || i_ex_ready;
    assign w_load     = i_id_valid && o_id_ready && !i_flush;
    assign w_stall    = r_valid && !i_ex_ready;

`ifdef RISCV_FWD_EN
    logic [REG_AW-1:0] r_rs1_addr;
    logic [REG_AW-1:0] r_rs2_addr;
    logic [REG_AW-1:0] w_rs1_sel_addr;
    logic [REG_AW-1:0] w_rs2_sel_addr;
    logic [XLEN-1:0]   w_rs1_base;
    logic [XLEN-1:0]   w_rs2_base;

    // On load forward onto the incoming operands; otherwise refresh the held ones.
    assign w_rs1_sel_addr = w_load ? i_id_rs1_addr : r_rs1_addr;
    assign w_rs2_sel_addr = w_load ? i_id_rs2_addr : r_rs2_addr;
    assign w_rs1_base     = w_load ? i_id_rs1_data : r_rs1;
    assign w_rs2_base     = w_load ? i_id_rs2_data : r_rs2;

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_rs1_addr <= '0;
            r_rs2_addr <= '0;
        end else if (w_load) begin
            r_rs1_addr <= i_id_rs1_addr;
            r_rs2_addr <= i_id_rs2_addr;
        end
    end

    riscv_fwd_mux #(.XLEN(XLEN)) u_fwd_rs1 (
        .i_rs_addr       (w_rs1_sel_addr),
        .i_base          (w_rs1_base),
        .i_exmem_rd_addr (i_exmem_rd_addr),
        .i_exmem_rd_we   (i_exmem_rd_we),
        .i_exmem_result  (i_exmem_result),
        .i_memwb_rd_addr (i_memwb_rd_addr),
        .i_memwb_rd_we   (i_memwb_rd_we),
        .i_memwb_result  (i_memwb_result),
        .o_value         (w_rs1_next)
    );

    riscv_fwd_mux #(.XLEN(XLEN)) u_fwd_rs2 (
        .i_rs_addr       (w_rs2_sel_addr),
        .i_base          (w_rs2_base),
        .i_exmem_rd_addr (i_exmem_rd_addr),
        .i_exmem_rd_we   (i_exmem_rd_we),
        .i_exmem_result  (i_exmem_result),
        .i_memwb_rd_addr (i_memwb_rd_addr),
        .i_memwb_rd_we   (i_memwb_rd_we),
        .i_memwb_result  (i_memwb_result),
        .o_value         (w_rs2_next)
    );
`else
    logic w_unused_fwd;

    // Without forwarding the operands come straight from the regfile.
    assign w_rs1_next   = i_id_rs1_data;
    assign w_rs2_next   = i_id_rs2_data;
    assign w_unused_fwd = ^{i_id_rs1_addr, i_id_rs2_addr,
                            i_exmem_rd_addr, i_exmem_rd_we, i_exmem_result,
                            i_memwb_rd_addr, i_memwb_rd_we, i_memwb_result};
`endif

    // Flush beats load beats stall; a consumed entry without a replacement retires.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_valid          <= 1'b0;
            r_rd_we          <= 1'b0;
            r_pc             <= '0;
            r_rs1            <= '0;
            r_rs2            <= '0;
            r_imm            <= '0;
            r_ctrl.alu_ctrl  <= ALU_CTRL_ADD;
            r_ctrl.src_a_sel <= SRC_A_RS1;
            r_ctrl.src_b_sel <= SRC_B_RS2;
            r_ctrl.rd_addr   <= '0;
        end else if (i_flush) begin
            r_valid <= 1'b0;
            r_rd_we <= 1'b0;
        end else if (w_load) begin
            r_valid          <= 1'b1;
            r_rd_we          <= i_id_rd_we;
            r_pc             <= i_id_pc;
            r_rs1            <= w_rs1_next;
            r_rs2            <= w_rs2_next;
            r_imm            <= i_id_imm;
            r_ctrl.alu_ctrl  <= alu_ctrl_e'(i_id_alu_ctrl);
            r_ctrl.src_a_sel <= src_a_e'(i_id_src_a_sel);
            r_ctrl.src_b_sel <= src_b_e'(i_id_src_b_sel);
            r_ctrl.rd_addr   <= i_id_rd_addr;
        end else if (w_stall) begin
`ifdef RISCV_FWD_EN
            r_rs1 <= w_rs1_next;
            r_rs2 <= w_rs2_next;
`endif
        end else begin
            r_valid <= 1'b0;
            r_rd_we <= 1'b0;
        end
    end

    assign o_ex_valid    = r_valid;
    assign o_ex_rd_we    = r_rd_we;
    assign o_alu_a       = (r_ctrl.src_a_sel == SRC_A_PC)  ? r_pc  : r_rs1;
    assign o_alu_b       = (r_ctrl.src_b_sel == SRC_B_IMM) ? r_imm : r_rs2;
    assign o_alu_ctrl    = r_ctrl.alu_ctrl;
    assign o_ex_rs2_data = r_rs2;
    assign o_ex_rd_addr  = r_ctrl.rd_addr;
    assign o_ex_pc       = r_pc;

endmodule

// File: tb/tb_riscv_idex_stage.sv
// Self-checking bench for riscv_idex_stage: directed scenarios then randomized traffic against a reference model.
// Forwarding scenarios are included when RISCV_FWD_EN is defined.
module tb_riscv_idex_stage;
    import riscv_idex_stage_pkg::*;

    logic        clk;
    logic        rstn;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_pc, id_rs1_data, id_rs2_data, id_imm;
    logic [4:0]  id_rs1_addr, id_rs2_addr, id_rd_addr;
    logic [3:0]  id_alu_ctrl;
    logic        id_src_a_sel, id_src_b_sel, id_rd_we;
    logic        flush, ex_ready;
    logic [4:0]  exmem_rd_addr, memwb_rd_addr;
    logic        exmem_rd_we, memwb_rd_we;
    logic [31:0] exmem_result, memwb_result;
    logic        ex_valid;
    logic [31:0] alu_a, alu_b, ex_rs2_data, ex_pc;
    logic [3:0]  alu_ctrl;
    logic [4:0]  ex_rd_addr;
    logic        ex_rd_we;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        valid, we, sa, sb;
        logic [31:0] pc, rs1, rs2, imm;
        logic [4:0]  rs1a, rs2a, rd;
        logic [3:0]  ctrl;
    } ent_t;
    ent_t m;

    riscv_idex_stage dut (
        .i_clk(clk), .i_rstn(rstn),
        .i_id_valid(id_valid), .o_id_ready(id_ready),
        .i_id_pc(id_pc), .i_id_rs1_data(id_rs1_data), .i_id_rs2_data(id_rs2_data),
        .i_id_rs1_addr(id_rs1_addr), .i_id_rs2_addr(id_rs2_addr), .i_id_imm(id_imm),
        .i_id_alu_ctrl(id_alu_ctrl), .i_id_src_a_sel(id_src_a_sel), .i_id_src_b_sel(id_src_b_sel),
        .i_id_rd_addr(id_rd_addr), .i_id_rd_we(id_rd_we),
        .i_flush(flush), .i_ex_ready(ex_ready),
        .i_exmem_rd_addr(exmem_rd_addr), .i_exmem_rd_we(exmem_rd_we), .i_exmem_result(exmem_result),
        .i_memwb_rd_addr(memwb_rd_addr), .i_memwb_rd_we(memwb_rd_we), .i_memwb_result(memwb_result),
        .o_ex_valid(ex_valid), .o_alu_a(alu_a), .o_alu_b(alu_b), .o_alu_ctrl(alu_ctrl),
        .o_ex_rs2_data(ex_rs2_data), .o_ex_rd_addr(ex_rd_addr), .o_ex_rd_we(ex_rd_we), .o_ex_pc(ex_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Newest producer wins; x0 is hard-wired and never taken from a producer.
    function automatic logic [31:0] fwd_val(input logic [4:0] a, input logic [31:0] base);
        if (a == 5'd0) return base;
        if (exmem_rd_we && exmem_rd_addr == a) return exmem_result;
        if (memwb_rd_we && memwb_rd_addr == a) return memwb_result;
        return base;
    endfunction

    task automatic model_reset();
        m = '{valid: 1'b0, we: 1'b0, sa: 1'b0, sb: 1'b0, pc: 32'h0, rs1: 32'h0, rs2: 32'h0,
              imm: 32'h0, rs1a: 5'h0, rs2a: 5'h0, rd: 5'h0, ctrl: 4'h0};
    endtask

    task automatic check_all();
        chk("ex_valid", 32'(ex_valid), 32'(m.valid));
        chk("ex_rd_we", 32'(ex_rd_we), 32'(m.we));
        chk("alu_a", alu_a, m.sa ? m.pc : m.rs1);
        chk("alu_b", alu_b, m.sb ? m.imm : m.rs2);
        chk("alu_ctrl", 32'(alu_ctrl), 32'(m.ctrl));
        chk("rs2_data", ex_rs2_data, m.rs2);
        chk("rd_addr", 32'(ex_rd_addr), 32'(m.rd));
        chk("ex_pc", ex_pc, m.pc);
        chk("id_ready", 32'(id_ready), 32'(!m.valid || ex_ready));
    endtask

    // One clock: predict from current inputs, advance, then compare on the falling edge.
    task automatic cycle();
        ent_t n;
        logic rdy;
        n   = m;
        rdy = !m.valid || ex_ready;
        if (flush) begin
            n.valid = 1'b0;
            n.we    = 1'b0;
        end else if (id_valid && rdy) begin
            n.valid = 1'b1;
            n.we    = id_rd_we;
            n.pc    = id_pc;
            n.imm   = id_imm;
            n.ctrl  = id_alu_ctrl;
            n.sa    = id_src_a_sel;
            n.sb    = id_src_b_sel;
            n.rd    = id_rd_addr;
            n.rs1a  = id_rs1_addr;
            n.rs2a  = id_rs2_addr;
`ifdef RISCV_FWD_EN
            n.rs1   = fwd_val(id_rs1_addr, id_rs1_data);
            n.rs2   = fwd_val(id_rs2_addr, id_rs2_data);
`else
            n.rs1   = id_rs1_data;
            n.rs2   = id_rs2_data;
`endif
        end else if (m.valid && !ex_ready) begin
`ifdef RISCV_FWD_EN
            n.rs1 = fwd_val(m.rs1a, m.rs1);
            n.rs2 = fwd_val(m.rs2a, m.rs2);
`endif
        end else begin
            n.valid = 1'b0;
            n.we    = 1'b0;
        end
        @(posedge clk);
        m = n;
        @(negedge clk);
        check_all();
    endtask

    task automatic drive_idle();
        id_valid = 0; id_pc = 0; id_rs1_data = 0; id_rs2_data = 0; id_imm = 0;
        id_rs1_addr = 0; id_rs2_addr = 0; id_rd_addr = 0; id_alu_ctrl = 0;
        id_src_a_sel = 0; id_src_b_sel = 0; id_rd_we = 0; flush = 0; ex_ready = 1;
        exmem_rd_addr = 0; exmem_rd_we = 0; exmem_result = 0;
        memwb_rd_addr = 0; memwb_rd_we = 0; memwb_result = 0;
    endtask

    task automatic drive_random();
        id_valid     = ($urandom_range(0, 3) != 0);
        id_pc        = $urandom;
        id_rs1_data  = $urandom;
        id_rs2_data  = $urandom;
        id_imm       = $urandom;
        id_rs1_addr  = 5'($urandom_range(0, 3));
        id_rs2_addr  = 5'($urandom_range(0, 3));
        id_rd_addr   = 5'($urandom);
        id_alu_ctrl  = 4'($urandom);
        id_src_a_sel = 1'($urandom);
        id_src_b_sel = 1'($urandom);
        id_rd_we     = 1'($urandom);
        flush        = ($urandom_range(0, 7) == 0);
        ex_ready     = 1'($urandom);
        exmem_rd_addr = 5'($urandom_range(0, 3));
        exmem_rd_we   = 1'($urandom);
        exmem_result  = $urandom;
        memwb_rd_addr = 5'($urandom_range(0, 3));
        memwb_rd_we   = 1'($urandom);
        memwb_result  = $urandom;
    endtask

    initial begin
        rstn = 1'b0;
        drive_idle();
        model_reset();
        repeat (2) @(negedge clk);
        check_all();
        chk("reset_ctrl_add", 32'(alu_ctrl), 32'(ALU_CTRL_ADD));
        rstn = 1'b1;

        // ADDI x2, x1, 7 with x1 = 5
        id_valid = 1; id_rs1_addr = 5'd1; id_rs1_data = 32'd5; id_imm = 32'd7;
        id_src_b_sel = 1; id_alu_ctrl = 4'(ALU_CTRL_ADD); id_rd_addr = 5'd2; id_rd_we = 1;
        id_pc = 32'h100;
        cycle();
        chk("addi_a", alu_a, 32'd5);
        chk("addi_b", alu_b, 32'd7);
        chk("addi_valid", 32'(ex_valid), 32'd1);
        chk("addi_ready", 32'(id_ready), 32'd1);

        // Stall three cycles with a new instruction waiting
        ex_ready = 0; id_rs1_data = 32'd9; id_imm = 32'd3; id_pc = 32'h104; id_rd_addr = 5'd6;
        for (int i = 0; i < 3; i++) begin
            cycle();
            chk("stall_ready", 32'(id_ready), 32'd0);
            chk("stall_a", alu_a, 32'd5);
            chk("stall_rd", 32'(ex_rd_addr), 32'd2);
        end
        ex_ready = 1;
        cycle();
        chk("post_stall_a", alu_a, 32'd9);
        chk("post_stall_b", alu_b, 32'd3);
        chk("post_stall_valid", 32'(ex_valid), 32'd1);

        // Flush together with an incoming instruction
        flush = 1; id_rs1_data = 32'h77;
        cycle();
        chk("flush_valid", 32'(ex_valid), 32'd0);
        chk("flush_we", 32'(ex_rd_we), 32'd0);
        flush = 0;
        cycle();
        chk("reload_valid", 32'(ex_valid), 32'd1);
        chk("reload_a", alu_a, 32'h77);

`ifdef RISCV_FWD_EN
        drive_idle();
        id_valid = 1; id_rs1_addr = 5'd3; id_rs1_data = 32'h11;
        exmem_rd_addr = 5'd3; exmem_rd_we = 1; exmem_result = 32'hAA;
        memwb_rd_addr = 5'd3; memwb_rd_we = 1; memwb_result = 32'hBB;
        cycle();
        chk("fwd_exmem", alu_a, 32'hAA);
        exmem_rd_we = 0;
        cycle();
        chk("fwd_memwb", alu_a, 32'hBB);
        id_rs1_addr = 5'd0; exmem_rd_addr = 5'd0; exmem_rd_we = 1;
        memwb_rd_addr = 5'd0;
        cycle();
        chk("fwd_x0", alu_a, 32'h11);

        drive_idle();
        id_valid = 1; id_rs2_addr = 5'd4; id_rs2_data = 32'h55;
        cycle();
        id_valid = 0; ex_ready = 0;
        cycle();
        chk("refresh_pre", alu_b, 32'h55);
        memwb_rd_addr = 5'd4; memwb_rd_we = 1; memwb_result = 32'h1234;
        cycle();
        chk("refresh_hit", alu_b, 32'h1234);
        memwb_rd_we = 0; memwb_result = 32'h0;
        cycle();
        chk("refresh_hold", alu_b, 32'h1234);
        chk("refresh_store", ex_rs2_data, 32'h1234);
`endif

        // Asynchronous reset in the middle of a stall
        drive_idle();
        id_valid = 1; id_alu_ctrl = 4'(ALU_CTRL_SUB); id_rd_we = 1; id_rs1_data = 32'h42;
        cycle();
        id_valid = 0; ex_ready = 0;
        cycle();
        chk("pre_reset_valid", 32'(ex_valid), 32'd1);
        #2 rstn = 1'b0;
        #1;
        chk("async_valid", 32'(ex_valid), 32'd0);
        chk("async_ctrl", 32'(alu_ctrl), 32'(ALU_CTRL_ADD));
        chk("async_we", 32'(ex_rd_we), 32'd0);
        model_reset();
        @(negedge clk);
        rstn = 1'b1;
        drive_idle();
        check_all();

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            drive_random();
            cycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
